// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester front end for the single-port data memory.
// Port 0 is the core load/store path, port 1 is the debug/DMA loader.
// Grants are combinational; read data comes back registered one cycle later.

// Purpose: round-robin grant between core (port 0) and loader (port 1), with a bounded port 1 burst lock.
// Latency: grant and memory drive in the request cycle; read data and rvalid one cycle after grant.
// Backpressure: a requester holds req/we/addr/wdata until its gnt is seen; port 0 waits at most MAX_BURST contended cycles.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4   // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Burst counter is 4 bits and saturates at 15, so the limit fits the same width.
  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
  localparam logic [3:0] BURST_SAT   = 4'd15;

  // One request as presented by a requester.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t w_m0_dat;
  req_t w_m1_dat;
  req_t w_sel_dat;

  logic w_gnt0;
  logic w_gnt1;

  // Arbitration state: who won last, whether port 1 holds a lock, and how long port 0 has been starved.
  logic       r_last_grant;
  logic [3:0] r_burst_cnt;
  logic       r_lock_active;

  // Registered read return, one set per port.
  logic              r_m0_rvalid;
  logic [DATA_W-1:0] r_m0_rdata;
  logic              r_m1_rvalid;
  logic [DATA_W-1:0] r_m1_rdata;

  assign w_m0_dat = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
  assign w_m1_dat = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};

  // Grant selection: lone requester wins; under contention an unexhausted port 1 lock wins,
  // otherwise the port that did not win last time. Nothing is granted while reset is high.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (m0_req && !m1_req) begin
        w_gnt0 = 1'b1;
      end else if (m1_req && !m0_req) begin
        w_gnt1 = 1'b1;
      end else if (m0_req && m1_req) begin
        if (r_lock_active && (r_burst_cnt < BURST_LIMIT)) begin
          w_gnt1 = 1'b1;
        end else if (r_last_grant) begin
          w_gnt0 = 1'b1;
        end else begin
          w_gnt1 = 1'b1;
        end
      end
    end
  end

  // Memory drive mux: port 1 only when it holds the grant, so idle cycles present port 0's address/data.
  always_comb begin
    w_sel_dat = w_m0_dat;
    if (w_gnt1) begin
      w_sel_dat = w_m1_dat;
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign mem_addr  = w_sel_dat.addr;
  assign mem_wdata = w_sel_dat.wdata;
  assign mem_write = (w_gnt0 &  m0_we) | (w_gnt1 &  m1_we);
  assign mem_read  = (w_gnt0 & ~m0_we) | (w_gnt1 & ~m1_we);

  // Round-robin pointer and lock flag: updated on any grant, held through idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant  <= 1'b1;  // port 0 wins the first contended cycle
      r_lock_active <= 1'b0;
    end else if (w_gnt0) begin
      r_last_grant  <= 1'b0;
      r_lock_active <= 1'b0;
    end else if (w_gnt1) begin
      r_last_grant  <= 1'b1;
      r_lock_active <= m1_lock;
    end
  end

  // Starvation counter: counts port 1 grants that port 0 sat through; any relief for port 0
  // (its own grant, or it stops asking) starts the count over.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_burst_cnt <= 4'd0;
    end else if (!m0_req || w_gnt0) begin
      r_burst_cnt <= 4'd0;
    end else if (w_gnt1 && (r_burst_cnt != BURST_SAT)) begin
      r_burst_cnt <= r_burst_cnt + 4'd1;
    end
  end

  // Port 0 read return: capture memory data at the end of a read grant, pulse rvalid for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m0_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
    end else begin
      r_m0_rvalid <= w_gnt0 & ~m0_we;
      if (w_gnt0 && !m0_we) begin
        r_m0_rdata <= mem_rdata;
      end
    end
  end

  // Port 1 read return: same timing as port 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m1_rvalid <= 1'b0;
      r_m1_rdata  <= '0;
    end else begin
      r_m1_rvalid <= w_gnt1 & ~m1_we;
      if (w_gnt1 && !m1_we) begin
        r_m1_rdata <= mem_rdata;
      end
    end
  end

  assign m0_rvalid = r_m0_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rvalid = r_m1_rvalid;
  assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural memory and a read-return scoreboard.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  bit mon_en = 0;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;

  rd_t q0[$];
  rd_t q1[$];

  logic [31:0] mem [0:63];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, write at the clock edge.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    cyc_n <= cyc_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Read-return scoreboard: each cycle rvalid must match whether a read is due, and data must match.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q0.size() > 0 && q0[0].due == cyc_n) begin
        chkb("m0_rvalid", m0_rvalid, 1'b1);
        chk("m0_rdata", m0_rdata, q0[0].d);
        void'(q0.pop_front());
      end else begin
        chkb("m0_rvalid_idle", m0_rvalid, 1'b0);
      end
      if (q1.size() > 0 && q1[0].due == cyc_n) begin
        chkb("m1_rvalid", m1_rvalid, 1'b1);
        chk("m1_rdata", m1_rdata, q1[0].d);
        void'(q1.pop_front());
      end else begin
        chkb("m1_rvalid_idle", m1_rvalid, 1'b0);
      end
    end
  end

  task automatic drv(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                     input logic lk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    m1_lock = lk;
  endtask

  // One clock cycle with the expected grant pair; checks the memory drive and queues expected reads.
  task automatic cyc(input string tag, input logic e0, input logic e1);
    rd_t ent;
    @(negedge clk);
    chkb({tag, ".g0"}, m0_gnt, e0);
    chkb({tag, ".g1"}, m1_gnt, e1);
    chkb({tag, ".wr"}, mem_write, (e0 & m0_we) | (e1 & m1_we));
    chkb({tag, ".rd"}, mem_read, (e0 & ~m0_we) | (e1 & ~m1_we));
    chk({tag, ".addr"}, mem_addr, e1 ? m1_addr : m0_addr);
    if (e0 && !m0_we) begin
      ent.due = cyc_n + 1; ent.d = mem[m0_addr[7:2]]; q0.push_back(ent);
    end
    if (e1 && !m1_we) begin
      ent.due = cyc_n + 1; ent.d = mem[m1_addr[7:2]]; q1.push_back(ent);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit [8:0] t3_pat;
    int       k;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;  // 0x10
    mem[5] = 32'hCAFEF00D;  // 0x14
    for (int i = 16; i < 32; i++) mem[i] = 32'hA5000000 | 32'(i);

    reset = 1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    mon_en = 1;
    cyc("rst", 0, 0);
    chkb("rst.m0_rvalid", m0_rvalid, 1'b0);
    chkb("rst.m1_rvalid", m1_rvalid, 1'b0);
    chk("rst.m0_rdata", m0_rdata, 32'h0);
    chk("rst.m1_rdata", m1_rdata, 32'h0);
    reset = 0;

    // 1: single port 0 read, data returns next cycle and holds
    drv(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    cyc("t1", 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t1_idle", 0, 0);
    chk("t1.hold", m0_rdata, 32'hDEADBEEF);

    // 2: both write continuously; port 0 won last, so port 1 goes first
    drv(1, 1, 32'h20, 32'h11, 1, 1, 32'h24, 32'h22, 0);
    cyc("t2a", 0, 1);
    cyc("t2b", 1, 0);
    cyc("t2c", 0, 1);
    cyc("t2d", 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t2_idle", 0, 0);
    chk("t2.mem20", mem[8], 32'h11);
    chk("t2.mem24", mem[9], 32'h22);

    // 3: locked 8-read burst on port 1 with port 0 always waiting: 4 m1, 1 m0, 4 m1
    t3_pat = 9'b111101111;
    k = 0;
    for (int i = 0; i < 9; i++) begin
      drv(1, 0, 32'h10, 0, 1, 0, 32'h40 + 32'(4 * k), 0, 1);
      cyc($sformatf("t3.%0d", i), ~t3_pat[i], t3_pat[i]);
      if (t3_pat[i]) k++;
    end

    // 4: locked port 1 alone is granted every cycle and builds no starvation count,
    //    so a later contended run still gives port 1 a full burst of 4
    for (int i = 0; i < 6; i++) begin
      drv(0, 0, 0, 0, 1, 0, 32'h44, 0, 1);
      cyc($sformatf("t4.solo%0d", i), 0, 1);
    end
    for (int i = 0; i < 5; i++) begin
      drv(1, 0, 32'h10, 0, 1, 0, 32'h48, 0, 1);
      cyc($sformatf("t4.cont%0d", i), (i == 4), (i != 4));
    end

    // 6: idle cycles leave the round-robin pointer alone (port 0 won last)
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t6_idle0", 0, 0);
    cyc("t6_idle1", 0, 0);
    cyc("t6_idle2", 0, 0);
    drv(1, 0, 32'h10, 0, 1, 0, 32'h44, 0, 0);
    cyc("t6_cont", 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t6_end", 0, 0);

    // 5: reset right after a port 0 read grant clears the return path
    drv(1, 0, 32'h14, 0, 0, 0, 0, 0, 0);
    cyc("t5_gnt", 1, 0);
    reset = 1;
    drv(1, 0, 32'h14, 0, 1, 0, 32'h44, 0, 1);
    cyc("t5_rst0", 0, 0);
    chkb("t5.m0_rvalid", m0_rvalid, 1'b0);
    chk("t5.m0_rdata", m0_rdata, 32'h0);
    chk("t5.m1_rdata", m1_rdata, 32'h0);
    cyc("t5_rst1", 0, 0);
    reset = 0;
    drv(1, 0, 32'h14, 0, 1, 0, 32'h44, 0, 0);
    cyc("t5_rel0", 1, 0);
    cyc("t5_rel1", 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t5_idle0", 0, 0);
    cyc("t5_idle1", 0, 0);

    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
